sw_debounce: RTL

- Input-conditioning stage directly upstream of the I/O input port register that latches the slide switches.
- Synchronizes raw asynchronous switch lines into the clock domain and debounces each bit independently.
- Outputs a clean switch vector plus one-cycle rise/fall event pulses and a sticky "changed" flag, which the CPU polls through the I/O input mux.

---
 rtl/sw_debounce.sv | 106 ++++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// sw_debounce
//   Conditions the raw slide-switch lines that feed the I/O input port
//   register. Each bit goes through a two-flop synchronizer. It is then
//   debounced on its own: the stable value only follows the synchronized
//   level after that level has differed from it for DEBOUNCE_CYCLES
//   consecutive cycles. Single-cycle rise/fall pulses and a sticky changed
//   flag are generated for the CPU to poll.
//
// Ports
//   clock          system clock, all state updates on posedge
//   reset          asynchronous, active-high reset
//   sw_raw         raw switch levels, asynchronous to clock
//   clear_changed  synchronous request to clear the changed flag
//   sw_stable      debounced switch vector
//   sw_rise        one-cycle pulse per bit on a stable 0->1 transition
//   sw_fall        one-cycle pulse per bit on a stable 1->0 transition
//   changed        sticky: some stable bit changed since the last clear
module sw_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             clear_changed,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_nxt  [WIDTH];
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    logic             changed_nxt;

    // Only sync1 ever samples sw_raw.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // The terminal compare comes before the increment. This means the counter
    // never wraps. A bit that matches its stable value again restarts its count.
    always_comb begin
        stable_nxt = sw_stable;
        rise_nxt   = '0;
        fall_nxt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sync2[i] == sw_stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_TERM) begin
                cnt_nxt[i]    = '0;
                stable_nxt[i] = sync2[i];
                rise_nxt[i]   = sync2[i];
                fall_nxt[i]   = ~sync2[i];
            end else begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    // A new event overrides a clear that arrives on the same edge.
    always_comb begin
        changed_nxt = changed;
        if (|(rise_nxt | fall_nxt)) begin
            changed_nxt = 1'b1;
        end else if (clear_changed) begin
            changed_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_stable <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            changed   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_stable <= stable_nxt;
            sw_rise   <= rise_nxt;
            sw_fall   <= fall_nxt;
            changed   <= changed_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
